ascon_pt_stage: RTL and testbench



---
 rtl/ascon_pt_stage_if.sv | 13 +
 rtl/ascon_pt_stage.sv | 124 ++++++++++++
 tb/tb_ascon_pt_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pt_stage_if.sv
// ascon_pt_stage_if: data-in / data-out handshake bundle for the ASCON plaintext stage
interface ascon_pt_stage_if;
  logic [63:0] din;
  logic        din_valid;
  logic        din_last;
  logic [2:0]  din_bytes;
  logic        din_ready;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  modport master (output din, din_valid, din_last, din_bytes, dout_ready, input din_ready, dout, dout_valid);
  modport slave (input din, din_valid, din_last, din_bytes, dout_ready, output din_ready, dout, dout_valid);
endinterface

// File: rtl/ascon_pt_stage.sv
// ascon_pt_stage: ASCON-128 data absorb stage with 6-round intermediate permutation
module ascon_pt_stage (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              decrypt,
  input  logic [63:0]       s0,
  input  logic [63:0]       s1,
  input  logic [63:0]       s2,
  input  logic [63:0]       s3,
  input  logic [63:0]       s4,
  ascon_pt_stage_if.slave   io,
  output logic [63:0]       x0,
  output logic [63:0]       x1,
  output logic [63:0]       x2,
  output logic [63:0]       x3,
  output logic [63:0]       x4,
  output logic              done,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, ABSORB, OUT, PERM, DONE} state_t;
  state_t st, st_n;
  logic [4:0][63:0] x, x_n;
  logic [63:0] dout_r, dout_n, mask, pad;
  logic [2:0] cnt, cnt_n;
  logic dec, dec_n, last, last_n;
  logic [3:0] n;
  logic [7:0] rc;
  function automatic logic [63:0] ror(input logic [63:0] v, input int k);
    return (v >> k) | (v << (64 - k));
  endfunction
  function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s, input logic [7:0] c);
    logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
    a0 = s[0];
    a1 = s[1];
    a2 = s[2] ^ {56'd0, c};
    a3 = s[3];
    a4 = s[4];
    a0 ^= a4;
    a4 ^= a3;
    a2 ^= a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 ^= t1;
    a1 ^= t2;
    a2 ^= t3;
    a3 ^= t4;
    a4 ^= t0;
    a1 ^= a0;
    a0 ^= a4;
    a3 ^= a2;
    a2 = ~a2;
    return {a4 ^ ror(a4, 7) ^ ror(a4, 41), a3 ^ ror(a3, 10) ^ ror(a3, 17),
            a2 ^ ror(a2, 1) ^ ror(a2, 6), a1 ^ ror(a1, 61) ^ ror(a1, 39),
            a0 ^ ror(a0, 19) ^ ror(a0, 28)};
  endfunction
  assign n = io.din_last ? {1'b0, io.din_bytes} : 4'd8;
  assign mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {n, 3'b000});
  assign pad = 64'h8000_0000_0000_0000 >> {n, 3'b000};
  assign rc = {4'd9 - {1'b0, cnt}, 4'd6 + {1'b0, cnt}};
  assign io.din_ready = st == ABSORB;
  assign io.dout_valid = st == OUT;
  assign io.dout = dout_r;
  assign done = st == DONE;
  assign busy = st != IDLE;
  assign x0 = x[0];
  assign x1 = x[1];
  assign x2 = x[2];
  assign x3 = x[3];
  assign x4 = x[4];
  // state register and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      x <= '0;
      dout_r <= '0;
      cnt <= '0;
      dec <= 1'b0;
      last <= 1'b0;
    end else begin
      st <= st_n;
      x <= x_n;
      dout_r <= dout_n;
      cnt <= cnt_n;
      dec <= dec_n;
      last <= last_n;
    end
  // next-state, absorb and permutation round
  always_comb begin
    st_n = st;
    x_n = x;
    dout_n = dout_r;
    cnt_n = cnt;
    dec_n = dec;
    last_n = last;
    case (st)
      IDLE: if (start) begin
        x_n = {s4 ^ 64'h1, s3, s2, s1, s0};
        dec_n = decrypt;
        st_n = ABSORB;
      end
      ABSORB: if (io.din_valid) begin
        dout_n = (x[0] ^ io.din) & mask;
        x_n[0] = dec ? ((io.din & mask) | (x[0] & ~mask)) ^ pad : x[0] ^ (io.din & mask) ^ pad;
        last_n = io.din_last;
        st_n = OUT;
      end
      OUT: if (io.dout_ready) begin
        cnt_n = '0;
        st_n = last ? DONE : PERM;
      end
      PERM: begin
        x_n = ascon_round(x, rc);
        cnt_n = cnt + 3'd1;
        st_n = cnt == 3'd5 ? ABSORB : PERM;
      end
      DONE: st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ascon_pt_stage.sv
// tb_ascon_pt_stage: directed bench with a byte-level ASCON model and per-cycle output compare
module tb_ascon_pt_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic decrypt = 1'b0;
  logic [63:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0, s4 = '0;
  logic [63:0] x0, x1, x2, x3, x4;
  logic done, busy;
  int errors = 0;
  int checks = 0;
  logic [63:0] m [5];
  logic mdec;
  logic [63:0] exp_dout = '0;
  logic [7:0] rc_tab [6] = '{8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
  logic [4:0] sbox_tab [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  ascon_pt_stage_if bus();
  ascon_pt_stage dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4),
    .io(bus),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] ror(input logic [63:0] v, input int k);
    return (v >> k) | (v << (64 - k));
  endfunction
  task automatic model_perm();
    logic [63:0] t [5];
    logic [4:0] o;
    for (int r = 0; r < 6; r++) begin
      m[2][7:0] = m[2][7:0] ^ rc_tab[r];
      for (int i = 0; i < 64; i++) begin
        o = sbox_tab[{m[0][i], m[1][i], m[2][i], m[3][i], m[4][i]}];
        for (int j = 0; j < 5; j++) t[j][i] = o[4 - j];
      end
      m[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
      m[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
      m[2] = t[2] ^ ror(t[2], 1) ^ ror(t[2], 6);
      m[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
      m[4] = t[4] ^ ror(t[4], 7) ^ ror(t[4], 41);
    end
  endtask
  task automatic model_absorb(input logic [63:0] d, input logic lst, input logic [2:0] nb);
    int n;
    logic [7:0] xb, db;
    n = lst ? int'(nb) : 8;
    exp_dout = '0;
    for (int b = 0; b < 8; b++) begin
      xb = m[0][63 - 8 * b -: 8];
      db = d[63 - 8 * b -: 8];
      if (b < n) begin
        exp_dout[63 - 8 * b -: 8] = xb ^ db;
        xb = mdec ? db : xb ^ db;
      end else if (b == n) xb = xb ^ 8'h80;
      m[0][63 - 8 * b -: 8] = xb;
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_din_ready"}, bus.din_ready, 0);
    check({tag, "_dout_valid"}, bus.dout_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_dout"}, bus.dout, 0);
    check({tag, "_x0"}, x0, 0);
    check({tag, "_x1"}, x1, 0);
    check({tag, "_x2"}, x2, 0);
    check({tag, "_x3"}, x3, 0);
    check({tag, "_x4"}, x4, 0);
  endtask
  task automatic start_op(input logic [63:0] a0, a1, a2, a3, a4, input logic d);
    @(negedge clk);
    s0 = a0; s1 = a1; s2 = a2; s3 = a3; s4 = a4;
    decrypt = d;
    start = 1'b1;
    m[0] = a0; m[1] = a1; m[2] = a2; m[3] = a3; m[4] = a4 ^ 64'h1;
    mdec = d;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("din_ready_after_start", bus.din_ready, 1);
  endtask
  task automatic send_block(input logic [63:0] d, input logic lst, input logic [2:0] nb,
                            input int hold, input logic abort);
    int k;
    k = 0;
    while (bus.din_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("din_ready_wait", bus.din_ready, 1);
    model_absorb(d, lst, nb);
    bus.din = d;
    bus.din_valid = 1'b1;
    bus.din_last = lst;
    bus.din_bytes = nb;
    bus.dout_ready = hold == 0;
    @(negedge clk);
    bus.din_valid = 1'b0;
    check("dout_valid_after_accept", bus.dout_valid, 1);
    check("din_ready_in_out", bus.din_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_dout_valid", bus.dout_valid, 1);
      check("hold_din_ready", bus.din_ready, 0);
      check("hold_dout", bus.dout, exp_dout);
      check("hold_x0", x0, m[0]);
      check("hold_x4", x4, m[4]);
    end
    bus.dout_ready = 1'b1;
    if (abort) begin
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("abort");
    end else if (lst) begin
      @(negedge clk);
      check("done_two_after_accept", done, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check("din_ready_low_in_perm", bus.din_ready, 0);
        check("busy_in_perm", busy, 1);
      end
      @(negedge clk);
      check("din_ready_eight_after", bus.din_ready, 1);
      model_perm();
    end
  endtask
  // per-cycle compare of every meaningful output against the model
  always @(negedge clk) begin
    if (bus.dout_valid) check("dout_model", bus.dout, exp_dout);
    if (done) begin
      check("x0_model", x0, m[0]);
      check("x1_model", x1, m[1]);
      check("x2_model", x2, m[2]);
      check("x3_model", x3, m[3]);
      check("x4_model", x4, m[4]);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [63:0] r0, r1, r2, r3, r4;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.din_last = 1'b0;
    bus.din_bytes = '0;
    bus.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    start_op(64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    send_block(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0, 0, 1'b0);
    check("empty_dout", bus.dout, 64'h0);
    check("empty_x0", x0, 64'h8000_0000_0000_0000);
    check("empty_x1", x1, 64'h0);
    check("empty_x2", x2, 64'h0);
    check("empty_x3", x3, 64'h0);
    check("empty_x4", x4, 64'h1);
    start_op(64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    send_block(64'hAABB_CCFF_FFFF_FFFF, 1'b1, 3'd3, 0, 1'b0);
    check("enc3_dout", bus.dout, 64'hAB98_8900_0000_0000);
    check("enc3_x0", x0, 64'hAB98_89E7_89AB_CDEF);
    start_op(64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1);
    send_block(64'hAB98_8912_3456_7890, 1'b1, 3'd3, 0, 1'b0);
    check("dec3_dout", bus.dout, 64'hAABB_CC00_0000_0000);
    check("dec3_x0", x0, 64'hAB98_89E7_89AB_CDEF);
    r0 = {$urandom, $urandom}; r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
    r3 = {$urandom, $urandom}; r4 = {$urandom, $urandom};
    start_op(r0, r1, r2, r3, r4, 1'b0);
    s0 = ~r0;
    decrypt = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_x0", x0, m[0]);
    check("start_ignored_ready", bus.din_ready, 1);
    send_block({$urandom, $urandom}, 1'b0, 3'd0, 0, 1'b0);
    send_block({$urandom, $urandom}, 1'b0, 3'd6, 0, 1'b0);
    send_block({$urandom, $urandom}, 1'b1, 3'd5, 0, 1'b0);
    start_op({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    send_block({$urandom, $urandom}, 1'b0, 3'd0, 5, 1'b0);
    send_block({$urandom, $urandom}, 1'b1, 3'd7, 0, 1'b0);
    start_op({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    send_block({$urandom, $urandom}, 1'b0, 3'd0, 0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("no_done_in_reset", done, 0);
    end
    rst_n = 1'b1;
    start_op({$urandom, $urandom}, 64'h0, {$urandom, $urandom}, 64'h0, {$urandom, $urandom}, 1'b0);
    send_block(64'h0123_4567_89AB_CDEF, 1'b1, 3'd0, 0, 1'b0);
    check("post_reset_empty_dout", bus.dout, 64'h0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
